// File: rtl/exec_unit.sv
// Execute stage behind the 8x16 register file: single-cycle ALU ops plus a 16-step iterative signed multiply.
// Latency: ALU ops write back 1 cycle after issue; MUL writes back 16 cycles after issue.
// Backpressure: in_ready drops for the whole multiply, so issue stalls until the MUL writeback cycle.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_valid/in_ready               issue handshake (op, rs1_value, rs2_value, rd sampled on accept)
//   wb_we/wb_reg/wb_value           one-cycle writeback to the register file write port
//   busy                            multiply in progress
//   flag_zero/flag_ovf              status of the last written result
module exec_unit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs1_value,
    input  logic [DATA_W-1:0] rs2_value,
    input  logic [REG_AW-1:0] rd,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_value,
    output logic              busy,
    output logic              flag_zero,
    output logic              flag_ovf
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int ACC_W = 2 * DATA_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                msign;
    logic [REG_AW-1:0]   mrd;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;

    // Handshake depends only on the state register, never on in_valid.
    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_MUL);

    // ---------------- single-cycle ALU ----------------
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [SH_W-1:0]   shamt;

    assign sum   = rs1_value + rs2_value;
    assign diff  = rs1_value - rs2_value;
    assign shamt = rs2_value[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (rs1_value[DATA_W-1] == rs2_value[DATA_W-1]) &&
                          (sum[DATA_W-1] != rs1_value[DATA_W-1]);
            end
            OP_SUB: begin
                // Overflow when operand signs differ and the result sign leaves A's sign.
                alu_res = diff;
                alu_ovf = (rs1_value[DATA_W-1] != rs2_value[DATA_W-1]) &&
                          (diff[DATA_W-1] != rs1_value[DATA_W-1]);
            end
            OP_AND:  alu_res = rs1_value & rs2_value;
            OP_OR:   alu_res = rs1_value | rs2_value;
            OP_XOR:  alu_res = rs1_value ^ rs2_value;
            OP_SLL:  alu_res = rs1_value << shamt;
            OP_SRA:  alu_res = $signed(rs1_value) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative multiply datapath ----------------
    // Magnitudes are unsigned DATA_W bits, so |-2^(DATA_W-1)| is representable.
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [ACC_W-1:0]  partial;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  product;
    logic              mul_ovf;
    logic              mul_last;

    assign abs_a    = rs1_value[DATA_W-1] ? (-rs1_value) : rs1_value;
    assign abs_b    = rs2_value[DATA_W-1] ? (-rs2_value) : rs2_value;
    assign partial  = {{DATA_W{1'b0}}, mag_a} << cnt;
    assign acc_next = acc + (mag_b[cnt] ? partial : '0);
    // The final step's sum is used directly so the writeback lands on the 16th step edge.
    assign product  = msign ? (-acc_next) : acc_next;
    // Fits in DATA_W signed bits only if the top DATA_W+1 bits are all equal.
    assign mul_ovf  = !((&product[ACC_W-1:DATA_W-1]) || !(|product[ACC_W-1:DATA_W-1]));
    assign mul_last = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wb_we     <= 1'b0;
            wb_reg    <= '0;
            wb_value  <= '0;
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            msign     <= 1'b0;
            mrd       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wb_we <= 1'b0;
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            mag_a <= abs_a;
                            mag_b <= abs_b;
                            msign <= rs1_value[DATA_W-1] ^ rs2_value[DATA_W-1];
                            mrd   <= rd;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            wb_we     <= 1'b1;
                            wb_reg    <= rd;
                            wb_value  <= alu_res;
                            flag_zero <= (alu_res == '0);
                            flag_ovf  <= alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    wb_we <= 1'b0;
                    if (mul_last) begin
                        state     <= S_IDLE;
                        wb_we     <= 1'b1;
                        wb_reg    <= mrd;
                        wb_value  <= product[DATA_W-1:0];
                        flag_zero <= (product[DATA_W-1:0] == '0);
                        flag_ovf  <= mul_ovf;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: table of single-cycle ops plus hand-written MUL/reset sequences.
// Expected writebacks are queued at issue time and compared by a monitor whenever wb_we is seen.
// Handshake/status signals are checked directly on the falling edge.
module tb_exec_unit;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [15:0] rs1_value = '0;
    logic [15:0] rs2_value = '0;
    logic [2:0]  rd = '0;
    logic        wb_we;
    logic [2:0]  wb_reg;
    logic [15:0] wb_value;
    logic        busy;
    logic        flag_zero;
    logic        flag_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
        logic [15:0] v;
        logic        z;
        logic        o;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] v;
        logic        z;
        logic        o;
    } exp_t;

    vec_t tbl[12];
    exp_t q[$];

    exec_unit #(.DATA_W(16), .REG_AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .rd        (rd),
        .wb_we     (wb_we),
        .wb_reg    (wb_reg),
        .wb_value  (wb_value),
        .busy      (busy),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] r);
        in_valid  = 1'b1;
        op        = o;
        rs1_value = a;
        rs2_value = b;
        rd        = r;
    endtask

    task automatic push(input logic [2:0] r, input logic [15:0] v, input logic z, input logic o);
        exp_t e;
        e.rd = r;
        e.v  = v;
        e.z  = z;
        e.o  = o;
        q.push_back(e);
    endtask

    // Scoreboard monitor: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wb_we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=reg %0d val %h required=no writeback @%0t",
                         wb_reg, wb_value, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_reg", 32'(wb_reg), 32'(e.rd));
                chk("wb_value", 32'(wb_value), 32'(e.v));
                chk("flag_zero", 32'(flag_zero), 32'(e.z));
                chk("flag_ovf", 32'(flag_ovf), 32'(e.o));
            end
        end
    end

    // MUL issue with an ADD (10+20 -> rd 6) requested throughout the busy period.
    task automatic mul_seq(input logic [15:0] a, input logic [15:0] b, input logic [2:0] r,
                           input logic [15:0] ev, input logic ez, input logic eo);
        drive(OP_MUL, a, b, r);
        push(r, ev, ez, eo);
        @(posedge clk); #1;
        drive(OP_ADD, 16'd10, 16'd20, 3'd6);
        push(3'd6, 16'd30, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_wb_we", 32'(wb_we), 32'd0);
        end
        @(negedge clk);
        chk("mul_done_wb_we", 32'(wb_we), 32'd1);
        chk("mul_done_in_ready", 32'(in_ready), 32'd1);
        chk("mul_done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_after_mul_wb_we", 32'(wb_we), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 3'd3, 16'h8000, 1'b0, 1'b1};
        tbl[1]  = '{OP_SUB, 16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{OP_XOR, 16'h00FF, 16'h0F0F, 3'd2, 16'h0FF0, 1'b0, 1'b0};
        tbl[3]  = '{OP_SRA, 16'h8000, 16'h0013, 3'd7, 16'hF000, 1'b0, 1'b0};
        tbl[4]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 3'd0, 16'h3030, 1'b0, 1'b0};
        tbl[5]  = '{OP_OR,  16'hF000, 16'h000F, 3'd4, 16'hF00F, 1'b0, 1'b0};
        tbl[6]  = '{OP_SLL, 16'h0003, 16'h0024, 3'd5, 16'h0030, 1'b0, 1'b0};
        tbl[7]  = '{OP_SUB, 16'h8000, 16'h0001, 3'd6, 16'h7FFF, 1'b0, 1'b1};
        tbl[8]  = '{OP_ADD, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{OP_SRA, 16'h7000, 16'h0002, 3'd2, 16'h1C00, 1'b0, 1'b0};
        tbl[10] = '{OP_ADD, 16'h8000, 16'h8000, 3'd1, 16'h0000, 1'b1, 1'b1};
        tbl[11] = '{OP_SLL, 16'h8001, 16'h0011, 3'd3, 16'h0002, 1'b0, 1'b0};

        // Reset with in_valid asserted: must be ignored.
        drive(OP_ADD, 16'h1111, 16'h2222, 3'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_value", 32'(wb_value), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {30'd0, flag_zero, flag_ovf}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_wb_we", 32'(wb_we), 32'd0);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops: wb_we must stay high continuously.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
            push(tbl[i].rd, tbl[i].v, tbl[i].z, tbl[i].o);
            @(negedge clk);
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) chk("b2b_wb_we", 32'(wb_we), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("last_wb_we", 32'(wb_we), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_wb_we", 32'(wb_we), 32'd0);
        chk("hold_wb_value", 32'(wb_value), 32'h0002);
        chk("hold_wb_reg", 32'(wb_reg), 32'd3);
        @(posedge clk); #1;

        mul_seq(16'hFFFD, 16'h0007, 3'd5, 16'hFFEB, 1'b0, 1'b0);
        mul_seq(16'h8000, 16'h8000, 3'd4, 16'h0000, 1'b1, 1'b1);
        mul_seq(16'd300,  16'd200,  3'd7, 16'hEA60, 1'b0, 1'b1);
        mul_seq(16'hFF00, 16'hFFFF, 3'd2, 16'h0100, 1'b0, 1'b0);

        // Reset during the 8th MUL step: no writeback, everything cleared.
        drive(OP_MUL, 16'd3, 16'd4, 3'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_wb_we", 32'(wb_we), 32'd0);
        chk("abort_wb_value", 32'(wb_value), 32'd0);
        chk("abort_wb_reg", 32'(wb_reg), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", {30'd0, flag_zero, flag_ovf}, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        drive(OP_ADD, 16'd2, 16'd2, 3'd0);
        push(3'd0, 16'd4, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_after_abort_wb_we", 32'(wb_we), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
